// File: rtl/mem_wb_sender_if.sv
// MEM->WB stage bundle: EX handshake, data-memory port and the WBReg_* outputs.
// MISALIGN_TRAP_EN adds the WBReg_misalign flag.
interface mem_wb_sender_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic                  ex_MemRd;
    logic                  ex_MemWr;
    logic [2:0]            ex_MemOp;
    logic [DATA_WIDTH-1:0] ex_ALUout;
    logic [DATA_WIDTH-1:0] ex_StoreData;
    logic [ADDR_WIDTH-1:0] ex_Regrd;
    logic                  ex_RegWr;
    logic                  ex_MemtoReg;
    logic [DATA_WIDTH-1:0] ex_PC;
    logic [DATA_WIDTH-1:0] ex_Instr;
    logic                  ex_diffen;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [DATA_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [3:0]            dmem_wmask;
    logic                  dmem_gnt;
    logic                  dmem_rvalid;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    logic                  WBReg_valid;
    logic                  WBReg_RegWr;
    logic                  WBReg_MemtoReg;
    logic [ADDR_WIDTH-1:0] WBReg_Regrd;
    logic [DATA_WIDTH-1:0] WBReg_ALUout;
    logic [DATA_WIDTH-1:0] WBReg_DataOut;
    logic [DATA_WIDTH-1:0] WBReg_PC;
    logic [DATA_WIDTH-1:0] WBReg_Instr;
    logic                  mem_diffen;
`ifdef MISALIGN_TRAP_EN
    logic                  WBReg_misalign;
`endif

    modport master (
`ifdef MISALIGN_TRAP_EN
        output WBReg_misalign,
`endif
        input  ex_valid, ex_MemRd, ex_MemWr, ex_MemOp, ex_ALUout, ex_StoreData,
        input  ex_Regrd, ex_RegWr, ex_MemtoReg, ex_PC, ex_Instr, ex_diffen,
        output ex_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output WBReg_valid, WBReg_RegWr, WBReg_MemtoReg, WBReg_Regrd,
        output WBReg_ALUout, WBReg_DataOut, WBReg_PC, WBReg_Instr, mem_diffen
    );

    modport slave (
`ifdef MISALIGN_TRAP_EN
        input  WBReg_misalign,
`endif
        output ex_valid, ex_MemRd, ex_MemWr, ex_MemOp, ex_ALUout, ex_StoreData,
        output ex_Regrd, ex_RegWr, ex_MemtoReg, ex_PC, ex_Instr, ex_diffen,
        input  ex_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  WBReg_valid, WBReg_RegWr, WBReg_MemtoReg, WBReg_Regrd,
        input  WBReg_ALUout, WBReg_DataOut, WBReg_PC, WBReg_Instr, mem_diffen
    );
endinterface

// File: rtl/mem_wb_sender.sv
// Memory stage: accepts EX results, runs loads/stores on the req/gnt/rvalid port, registers the WBReg_* bundle.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses retire without a memory request and flag WBReg_misalign.
//
// state | meaning
// IDLE  | ready for EX; non-memory instructions retire from here
// REQ   | dmem_req held until dmem_gnt
// RESP  | load granted, waiting for dmem_rvalid
module mem_wb_sender #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic              clk,
    input logic              rst_n,
    mem_wb_sender_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t                state;
    logic [DATA_WIDTH-1:0] h_alu;
    logic [DATA_WIDTH-1:0] h_pc;
    logic [DATA_WIDTH-1:0] h_instr;
    logic [ADDR_WIDTH-1:0] h_regrd;
    logic                  h_regwr;
    logic                  h_memtoreg;
    logic                  h_diffen;
    logic                  h_store;
    logic [1:0]            h_off;
    logic [1:0]            h_size;
    logic                  h_uns;

    logic [1:0]            in_size;
    logic                  in_uns;
    logic [1:0]            in_off;
    logic                  in_mem;
    logic [DATA_WIDTH-1:0] in_wdata;
    logic [3:0]            in_wmask;
`ifdef MISALIGN_TRAP_EN
    logic                  in_misal;
`endif

    // Undefined funct3 encodings fall into the word case.
    always_comb begin
        in_size  = SZ_W;
        in_uns   = 1'b0;
        in_off   = 2'b00;
        in_wdata = bus.ex_StoreData;
        in_wmask = 4'b1111;
        case (bus.ex_MemOp)
            3'b000, 3'b100: in_size = SZ_B;
            3'b001, 3'b101: in_size = SZ_H;
            default:        in_size = SZ_W;
        endcase
        in_uns = (bus.ex_MemOp == 3'b100) || (bus.ex_MemOp == 3'b101);
        case (in_size)
            SZ_B: begin
                in_off   = bus.ex_ALUout[1:0];
                in_wdata = {4{bus.ex_StoreData[7:0]}};
                in_wmask = 4'b0001 << in_off;
            end
            SZ_H: begin
                in_off   = {bus.ex_ALUout[1], 1'b0};
                in_wdata = {2{bus.ex_StoreData[15:0]}};
                in_wmask = 4'b0011 << in_off;
            end
            default: begin
                in_off   = 2'b00;
                in_wdata = bus.ex_StoreData;
                in_wmask = 4'b1111;
            end
        endcase
        in_mem = bus.ex_MemRd || bus.ex_MemWr;
`ifdef MISALIGN_TRAP_EN
        in_misal = ((in_size == SZ_H) && bus.ex_ALUout[0]) ||
                   ((in_size == SZ_W) && (bus.ex_ALUout[1:0] != 2'b00));
`endif
    end

    function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [1:0] off,
                                                       input logic [1:0] size,
                                                       input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            SZ_B:    load_ext = {{24{b[7] & ~uns}}, b};
            SZ_H:    load_ext = {{16{h[15] & ~uns}}, h};
            default: load_ext = w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            bus.ex_ready       <= 1'b0;
            bus.dmem_req       <= 1'b0;
            bus.dmem_we        <= 1'b0;
            bus.dmem_addr      <= '0;
            bus.dmem_wdata     <= '0;
            bus.dmem_wmask     <= '0;
            bus.WBReg_valid    <= 1'b0;
            bus.WBReg_RegWr    <= 1'b0;
            bus.WBReg_MemtoReg <= 1'b0;
            bus.WBReg_Regrd    <= '0;
            bus.WBReg_ALUout   <= '0;
            bus.WBReg_DataOut  <= '0;
            bus.WBReg_PC       <= '0;
            bus.WBReg_Instr    <= '0;
            bus.mem_diffen     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            bus.WBReg_misalign <= 1'b0;
`endif
            h_alu      <= '0;
            h_pc       <= '0;
            h_instr    <= '0;
            h_regrd    <= '0;
            h_regwr    <= 1'b0;
            h_memtoreg <= 1'b0;
            h_diffen   <= 1'b0;
            h_store    <= 1'b0;
            h_off      <= 2'b00;
            h_size     <= SZ_W;
            h_uns      <= 1'b0;
        end else begin
            bus.WBReg_valid <= 1'b0;
            bus.WBReg_RegWr <= 1'b0;
            case (state)
                IDLE: begin
                    bus.ex_ready <= 1'b1;
                    if (bus.ex_valid && bus.ex_ready) begin
                        h_alu      <= bus.ex_ALUout;
                        h_pc       <= bus.ex_PC;
                        h_instr    <= bus.ex_Instr;
                        h_regrd    <= bus.ex_Regrd;
                        h_regwr    <= bus.ex_RegWr;
                        h_memtoreg <= bus.ex_MemtoReg;
                        h_diffen   <= bus.ex_diffen;
                        h_store    <= bus.ex_MemWr;
                        h_off      <= in_off;
                        h_size     <= in_size;
                        h_uns      <= in_uns;
`ifdef MISALIGN_TRAP_EN
                        if (in_mem && in_misal) begin
                            bus.WBReg_valid    <= 1'b1;
                            bus.WBReg_RegWr    <= 1'b0;
                            bus.WBReg_MemtoReg <= bus.ex_MemtoReg;
                            bus.WBReg_Regrd    <= bus.ex_Regrd;
                            bus.WBReg_ALUout   <= bus.ex_ALUout;
                            bus.WBReg_DataOut  <= '0;
                            bus.WBReg_PC       <= bus.ex_PC;
                            bus.WBReg_Instr    <= bus.ex_Instr;
                            bus.mem_diffen     <= bus.ex_diffen;
                            bus.WBReg_misalign <= 1'b1;
                        end else
`endif
                        if (in_mem) begin
                            state          <= REQ;
                            bus.ex_ready   <= 1'b0;
                            bus.dmem_req   <= 1'b1;
                            bus.dmem_we    <= bus.ex_MemWr;
                            bus.dmem_addr  <= {bus.ex_ALUout[DATA_WIDTH-1:2], 2'b00};
                            bus.dmem_wdata <= bus.ex_MemWr ? in_wdata : '0;
                            bus.dmem_wmask <= bus.ex_MemWr ? in_wmask : 4'b0000;
                        end else begin
                            bus.WBReg_valid    <= 1'b1;
                            bus.WBReg_RegWr    <= bus.ex_RegWr;
                            bus.WBReg_MemtoReg <= bus.ex_MemtoReg;
                            bus.WBReg_Regrd    <= bus.ex_Regrd;
                            bus.WBReg_ALUout   <= bus.ex_ALUout;
                            bus.WBReg_DataOut  <= '0;
                            bus.WBReg_PC       <= bus.ex_PC;
                            bus.WBReg_Instr    <= bus.ex_Instr;
                            bus.mem_diffen     <= bus.ex_diffen;
`ifdef MISALIGN_TRAP_EN
                            bus.WBReg_misalign <= 1'b0;
`endif
                        end
                    end
                end
                REQ: begin
                    if (bus.dmem_gnt) begin
                        bus.dmem_req <= 1'b0;
                        bus.dmem_we  <= 1'b0;
                        if (h_store) begin
                            state              <= IDLE;
                            bus.ex_ready       <= 1'b1;
                            bus.WBReg_valid    <= 1'b1;
                            bus.WBReg_RegWr    <= h_regwr;
                            bus.WBReg_MemtoReg <= h_memtoreg;
                            bus.WBReg_Regrd    <= h_regrd;
                            bus.WBReg_ALUout   <= h_alu;
                            bus.WBReg_DataOut  <= '0;
                            bus.WBReg_PC       <= h_pc;
                            bus.WBReg_Instr    <= h_instr;
                            bus.mem_diffen     <= h_diffen;
`ifdef MISALIGN_TRAP_EN
                            bus.WBReg_misalign <= 1'b0;
`endif
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.dmem_rvalid) begin
                        state              <= IDLE;
                        bus.ex_ready       <= 1'b1;
                        bus.WBReg_valid    <= 1'b1;
                        bus.WBReg_RegWr    <= h_regwr;
                        bus.WBReg_MemtoReg <= h_memtoreg;
                        bus.WBReg_Regrd    <= h_regrd;
                        bus.WBReg_ALUout   <= h_alu;
                        bus.WBReg_DataOut  <= load_ext(bus.dmem_rdata, h_off, h_size, h_uns);
                        bus.WBReg_PC       <= h_pc;
                        bus.WBReg_Instr    <= h_instr;
                        bus.mem_diffen     <= h_diffen;
`ifdef MISALIGN_TRAP_EN
                        bus.WBReg_misalign <= 1'b0;
`endif
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.ex_ready <= 1'b0;
                    bus.dmem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wb_sender.sv
// Directed bench for mem_wb_sender: reset, ALU retire, stores, load extension, protocol corner cases.
module tb_mem_wb_sender;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    mem_wb_sender_if bus ();
    mem_wb_sender dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex();
        bus.ex_valid = 1'b0;
        bus.ex_MemRd = 1'b0;
        bus.ex_MemWr = 1'b0;
    endtask

    task automatic drive_ex(input logic rd, input logic wr, input logic [2:0] op,
                            input logic [31:0] alu, input logic [31:0] sd,
                            input logic [4:0] rw, input logic regwr, input logic m2r,
                            input logic [31:0] pc);
        bus.ex_valid     = 1'b1;
        bus.ex_MemRd     = rd;
        bus.ex_MemWr     = wr;
        bus.ex_MemOp     = op;
        bus.ex_ALUout    = alu;
        bus.ex_StoreData = sd;
        bus.ex_Regrd     = rw;
        bus.ex_RegWr     = regwr;
        bus.ex_MemtoReg  = m2r;
        bus.ex_PC        = pc;
        bus.ex_Instr     = pc ^ 32'h0000_0013;
        bus.ex_diffen    = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({bus.dmem_req, bus.WBReg_valid, bus.ex_ready, bus.WBReg_RegWr} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000", {bus.dmem_req, bus.WBReg_valid, bus.ex_ready, bus.WBReg_RegWr});
        end
        tests_run++;
        if ({bus.dmem_addr, bus.WBReg_ALUout, bus.WBReg_PC} !== 96'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 0", {bus.dmem_addr, bus.WBReg_ALUout, bus.WBReg_PC});
        end
        #2 rst_n = 1'b1;
        tick();
        tests_run++;
        if (bus.ex_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 1", bus.ex_ready);
        end
    endtask

    task automatic test_alu();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, pcs[i]);
            tick();
            tests_run++;
            if ({bus.WBReg_valid, bus.WBReg_RegWr, bus.WBReg_Regrd, bus.WBReg_ALUout, bus.WBReg_DataOut}
                !== {1'b1, 1'b1, 5'd5, 32'h1234, 32'h0}) begin
                tests_failed++;
                $display("FAIL alu_retire_%0d: got v=%b w=%b rd=%0d alu=%h do=%h expected 1 1 5 00001234 0",
                         i, bus.WBReg_valid, bus.WBReg_RegWr, bus.WBReg_Regrd, bus.WBReg_ALUout, bus.WBReg_DataOut);
            end
            tests_run++;
            if ({bus.WBReg_PC, bus.WBReg_Instr, bus.mem_diffen, bus.ex_ready}
                !== {pcs[i], pcs[i] ^ 32'h13, 1'b1, 1'b1}) begin
                tests_failed++;
                $display("FAIL alu_pass_%0d: got pc=%h ins=%h de=%b rdy=%b expected %h", i,
                         bus.WBReg_PC, bus.WBReg_Instr, bus.mem_diffen, bus.ex_ready, pcs[i]);
            end
        end
        idle_ex();
        tick();
        tests_run++;
        if ({bus.WBReg_valid, bus.WBReg_RegWr, bus.WBReg_ALUout} !== {1'b0, 1'b0, 32'h1234}) begin
            tests_failed++;
            $display("FAIL alu_hold: got v=%b w=%b alu=%h expected 0 0 00001234",
                     bus.WBReg_valid, bus.WBReg_RegWr, bus.WBReg_ALUout);
        end
    endtask

    task automatic test_store_sb_wait();
        int req_cycles;
        req_cycles = 0;
        drive_ex(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h1234_56A5, 5'd0, 1'b0, 1'b0, 32'h200);
        tick();
        idle_ex();
        tests_run++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_wmask, bus.dmem_wdata, bus.dmem_addr, bus.ex_ready}
            !== {1'b1, 1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h8000_0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL sb_request: got req=%b we=%b m=%b wd=%h a=%h rdy=%b expected 1 1 1000 a5a5a5a5 80000000 0",
                     bus.dmem_req, bus.dmem_we, bus.dmem_wmask, bus.dmem_wdata, bus.dmem_addr, bus.ex_ready);
        end
        if (bus.dmem_req) req_cycles++;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.dmem_req) req_cycles++;
            tests_run++;
            if ({bus.dmem_wmask, bus.dmem_wdata, bus.WBReg_valid} !== {4'b1000, 32'hA5A5_A5A5, 1'b0}) begin
                tests_failed++;
                $display("FAIL sb_stable_%0d: got m=%b wd=%h v=%b expected 1000 a5a5a5a5 0",
                         i, bus.dmem_wmask, bus.dmem_wdata, bus.WBReg_valid);
            end
        end
        tests_run++;
        if (req_cycles != 3) begin
            tests_failed++;
            $display("FAIL sb_req_cycles: got %0d expected 3", req_cycles);
        end
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        tests_run++;
        if ({bus.WBReg_valid, bus.WBReg_RegWr, bus.dmem_req, bus.WBReg_DataOut, bus.WBReg_PC}
            !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h200}) begin
            tests_failed++;
            $display("FAIL sb_retire: got v=%b w=%b req=%b do=%h pc=%h expected 1 0 0 0 200",
                     bus.WBReg_valid, bus.WBReg_RegWr, bus.dmem_req, bus.WBReg_DataOut, bus.WBReg_PC);
        end
        tick();
        tests_run++;
        if (bus.WBReg_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_single_retire: got %b expected 0", bus.WBReg_valid);
        end
    endtask

    task automatic store_case(input string nm, input logic rd, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_addr);
        drive_ex(rd, 1'b1, op, addr, data, 5'd0, 1'b0, 1'b0, 32'h300);
        tick();
        idle_ex();
        tests_run++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_wmask, bus.dmem_wdata, bus.dmem_addr}
            !== {1'b1, 1'b1, exp_mask, exp_wdata, exp_addr}) begin
            tests_failed++;
            $display("FAIL %s: got req=%b we=%b m=%b wd=%h a=%h expected 1 1 %b %h %h", nm,
                     bus.dmem_req, bus.dmem_we, bus.dmem_wmask, bus.dmem_wdata, bus.dmem_addr,
                     exp_mask, exp_wdata, exp_addr);
        end
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        tests_run++;
        if ({bus.WBReg_valid, bus.WBReg_RegWr, bus.ex_ready} !== 3'b101) begin
            tests_failed++;
            $display("FAIL %s_retire: got %b expected 101", nm, {bus.WBReg_valid, bus.WBReg_RegWr, bus.ex_ready});
        end
    endtask

    task automatic test_store_sizes();
        store_case("sh_upper", 1'b0, 3'b001, 32'h8000_0006, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h8000_0004);
        store_case("sb_lane1", 1'b0, 3'b000, 32'h8000_0011, 32'h0000_003C, 4'b0010, 32'h3C3C_3C3C, 32'h8000_0010);
        store_case("sw",       1'b0, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h8000_0008);
        store_case("rdwr_store", 1'b1, 3'b010, 32'h8000_0020, 32'h0102_0304, 4'b1111, 32'h0102_0304, 32'h8000_0020);
        store_case("undef_op_w", 1'b0, 3'b011, 32'h8000_000C, 32'h5566_7788, 4'b1111, 32'h5566_7788, 32'h8000_000C);
    endtask

    task automatic load_case(input string nm, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp_data,
                             input logic [31:0] exp_addr);
        drive_ex(1'b1, 1'b0, op, addr, 32'h0, 5'd7, 1'b1, 1'b1, 32'h400);
        tick();
        idle_ex();
        tests_run++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.WBReg_valid} !== {1'b1, 1'b0, exp_addr, 1'b0}) begin
            tests_failed++;
            $display("FAIL %s_req: got req=%b we=%b a=%h v=%b expected 1 0 %h 0", nm,
                     bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.WBReg_valid, exp_addr);
        end
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata = rdata;
        tests_run++;
        if ({bus.dmem_req, bus.WBReg_valid, bus.ex_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL %s_resp: got %b expected 000", nm, {bus.dmem_req, bus.WBReg_valid, bus.ex_ready});
        end
        tick();
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata = 32'h0;
        tests_run++;
        if ({bus.WBReg_valid, bus.WBReg_RegWr, bus.WBReg_MemtoReg, bus.WBReg_Regrd, bus.WBReg_DataOut, bus.WBReg_ALUout}
            !== {1'b1, 1'b1, 1'b1, 5'd7, exp_data, addr}) begin
            tests_failed++;
            $display("FAIL %s_data: got v=%b w=%b m2r=%b rd=%0d do=%h alu=%h expected 1 1 1 7 %h %h", nm,
                     bus.WBReg_valid, bus.WBReg_RegWr, bus.WBReg_MemtoReg, bus.WBReg_Regrd,
                     bus.WBReg_DataOut, bus.WBReg_ALUout, exp_data, addr);
        end
    endtask

    task automatic test_loads();
        load_case("lh",  3'b001, 32'h8000_0002, 32'h80FF_7F01, 32'hFFFF_80FF, 32'h8000_0000);
        load_case("lhu", 3'b101, 32'h8000_0002, 32'h80FF_7F01, 32'h0000_80FF, 32'h8000_0000);
        load_case("lb",  3'b000, 32'h8000_0001, 32'h80FF_7F01, 32'h0000_007F, 32'h8000_0000);
        load_case("lw",  3'b010, 32'h8000_0000, 32'h80FF_7F01, 32'h80FF_7F01, 32'h8000_0000);
        load_case("lb3", 3'b000, 32'h8000_0003, 32'h80FF_7F01, 32'hFFFF_FF80, 32'h8000_0000);
        load_case("lbu3", 3'b100, 32'h8000_0007, 32'h80FF_7F01, 32'h0000_0080, 32'h8000_0004);
        load_case("lh_lo", 3'b001, 32'h8000_0008, 32'h1234_F00D, 32'hFFFF_F00D, 32'h8000_0008);
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        drive_ex(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 5'd9, 1'b1, 1'b1, 32'h500);
        tick();
        idle_ex();
        tests_run++;
        if ({bus.dmem_req, bus.WBReg_valid, bus.WBReg_misalign, bus.WBReg_RegWr, bus.WBReg_DataOut, bus.ex_ready}
            !== {1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL misalign_trap: got req=%b v=%b mis=%b w=%b do=%h rdy=%b expected 0 1 1 0 0 1",
                     bus.dmem_req, bus.WBReg_valid, bus.WBReg_misalign, bus.WBReg_RegWr,
                     bus.WBReg_DataOut, bus.ex_ready);
        end
        tick();
        tests_run++;
        if ({bus.dmem_req, bus.WBReg_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL misalign_after: got %b expected 00", {bus.dmem_req, bus.WBReg_valid});
        end
`else
        load_case("lw_misal", 3'b010, 32'h8000_0002, 32'h80FF_7F01, 32'h80FF_7F01, 32'h8000_0000);
        load_case("lh_misal", 3'b001, 32'h8000_0001, 32'h80FF_7F01, 32'h0000_7F01, 32'h8000_0000);
`endif
    endtask

    task automatic test_protocol();
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        tests_run++;
        if ({bus.dmem_req, bus.WBReg_valid, bus.ex_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL stray_gnt_idle: got %b expected 001", {bus.dmem_req, bus.WBReg_valid, bus.ex_ready});
        end
        drive_ex(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd3, 1'b1, 1'b1, 32'h600);
        tick();
        idle_ex();
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.dmem_rvalid = 1'b0;
        tests_run++;
        if ({bus.dmem_req, bus.ex_ready, bus.WBReg_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL stray_rvalid_req: got %b expected 100", {bus.dmem_req, bus.ex_ready, bus.WBReg_valid});
        end
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({bus.ex_ready, bus.WBReg_valid, bus.dmem_req} !== 3'b000) begin
                tests_failed++;
                $display("FAIL resp_wait_%0d: got %b expected 000", i, {bus.ex_ready, bus.WBReg_valid, bus.dmem_req});
            end
        end
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata = 32'h1234_5678;
        tick();
        bus.dmem_rvalid = 1'b0;
        tests_run++;
        if ({bus.WBReg_valid, bus.WBReg_DataOut, bus.WBReg_Regrd} !== {1'b1, 32'h1234_5678, 5'd3}) begin
            tests_failed++;
            $display("FAIL delayed_retire: got v=%b do=%h rd=%0d expected 1 12345678 3",
                     bus.WBReg_valid, bus.WBReg_DataOut, bus.WBReg_Regrd);
        end
        tick();
        tests_run++;
        if ({bus.WBReg_valid, bus.ex_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL delayed_single: got %b expected 01", {bus.WBReg_valid, bus.ex_ready});
        end
    endtask

    task automatic test_reset_mid();
        drive_ex(1'b1, 1'b0, 3'b010, 32'h8000_0030, 32'h0, 5'd4, 1'b1, 1'b1, 32'h700);
        tick();
        idle_ex();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.dmem_req, bus.ex_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_in_req: got %b expected 00", {bus.dmem_req, bus.ex_ready});
        end
        #1 rst_n = 1'b1;
        tick();
        drive_ex(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'h0, 5'd4, 1'b1, 1'b1, 32'h704);
        tick();
        idle_ex();
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.dmem_req, bus.WBReg_valid, bus.ex_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_in_resp: got %b expected 000", {bus.dmem_req, bus.WBReg_valid, bus.ex_ready});
        end
        #1 rst_n = 1'b1;
        tick();
        tests_run++;
        if (bus.ex_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 1", bus.ex_ready);
        end
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.dmem_rvalid = 1'b0;
        tests_run++;
        if ({bus.WBReg_valid, bus.WBReg_DataOut} !== {1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_stray_rvalid: got v=%b do=%h expected 0 0", bus.WBReg_valid, bus.WBReg_DataOut);
        end
    endtask

    initial begin
        idle_ex();
        bus.ex_MemOp     = 3'b000;
        bus.ex_ALUout    = 32'h0;
        bus.ex_StoreData = 32'h0;
        bus.ex_Regrd     = 5'd0;
        bus.ex_RegWr     = 1'b0;
        bus.ex_MemtoReg  = 1'b0;
        bus.ex_PC        = 32'h0;
        bus.ex_Instr     = 32'h0;
        bus.ex_diffen    = 1'b0;
        bus.dmem_gnt     = 1'b0;
        bus.dmem_rvalid  = 1'b0;
        bus.dmem_rdata   = 32'h0;
        test_reset();
        test_alu();
        test_store_sb_wait();
        test_store_sizes();
        test_loads();
        test_misalign();
        test_protocol();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
